id_ex_stage: RTL

Decode-to-execute pipeline stage of the RV32I core: registers one decoded instruction per transfer and resolves MEM/WB forwarding. It drives the ALU's `control`, `left_operand` and `right_operand` inputs, and passes the memory and writeback controls downstream. It detects load-use hazards, holds on downstream stall, squashes on flush and keeps its stored operands coherent with writeback while stalled.

---
 rtl/id_ex_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, load-use bubble and stall refresh.
// Optional perf counters: define ID_EX_PERF_EN.
module id_ex_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_rs2_data,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_rs1_addr,
   input  logic [4:0]  in_rs2_addr,
   input  logic [4:0]  in_rd_addr,
   input  logic [3:0]  in_alu_control,
   input  logic        in_alu_src_pc,
   input  logic        in_alu_src_imm,
   input  logic        in_reg_write,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic        ex_ready,
   input  logic        flush,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_rd_addr,
   input  logic [31:0] mem_result,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd_addr,
   input  logic [31:0] wb_data,
   output logic        ex_valid,
   output logic [3:0]  alu_control,
   output logic [31:0] alu_left,
   output logic [31:0] alu_right,
   output logic [31:0] ex_store_data,
   output logic [31:0] ex_pc,
   output logic [4:0]  ex_rd_addr,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_count
`endif
);

   localparam logic [3:0] ALU_ADD = 4'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic [3:0]  alu_control;
      logic        src_pc;
      logic        src_imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } id_ex_t;

   id_ex_t      q;
   id_ex_t      d;
   logic        v;
   logic        hazard;
   logic        xfer_in;
   logic        xfer_out;
   logic [31:0] fwd1;
   logic [31:0] fwd2;

   always_comb begin
      d             = '0;
      d.pc          = in_pc;
      d.rs1_data    = in_rs1_data;
      d.rs2_data    = in_rs2_data;
      d.imm         = in_imm;
      d.rs1_addr    = in_rs1_addr;
      d.rs2_addr    = in_rs2_addr;
      d.rd_addr     = in_rd_addr;
      d.alu_control = in_alu_control;
      d.src_pc      = in_alu_src_pc;
      d.src_imm     = in_alu_src_imm;
      d.reg_write   = in_reg_write;
      d.mem_read    = in_mem_read;
      d.mem_write   = in_mem_write;
   end

   // conservative: flags a match even if the operand is unused
   assign hazard = v & q.mem_read & (q.rd_addr != 5'd0) &
                   ((q.rd_addr == in_rs1_addr) | (q.rd_addr == in_rs2_addr));
   assign in_ready = (~v | ex_ready) & ~hazard;
   assign xfer_in  = in_valid & in_ready;
   assign xfer_out = v & ex_ready;

   always_comb begin
      fwd1 = q.rs1_data;
      if (q.rs1_addr != 5'd0 && mem_reg_write && mem_rd_addr == q.rs1_addr)
         fwd1 = mem_result;
      else if (q.rs1_addr != 5'd0 && wb_reg_write && wb_rd_addr == q.rs1_addr)
         fwd1 = wb_data;
   end

   always_comb begin
      fwd2 = q.rs2_data;
      if (q.rs2_addr != 5'd0 && mem_reg_write && mem_rd_addr == q.rs2_addr)
         fwd2 = mem_result;
      else if (q.rs2_addr != 5'd0 && wb_reg_write && wb_rd_addr == q.rs2_addr)
         fwd2 = wb_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v    <= 1'b0;
         q    <= '0;
         q.pc <= RESET_PC;
      end else if (flush) begin
         v <= 1'b0;
      end else if (xfer_in) begin
         v <= 1'b1;
         q <= d;
      end else if (xfer_out) begin
         v <= 1'b0;
      end else if (v) begin
         // stalled: absorb WB so the value survives the producer retiring
         if (wb_reg_write && q.rs1_addr != 5'd0 && wb_rd_addr == q.rs1_addr)
            q.rs1_data <= wb_data;
         if (wb_reg_write && q.rs2_addr != 5'd0 && wb_rd_addr == q.rs2_addr)
            q.rs2_data <= wb_data;
      end
   end

   always_comb begin
      alu_control  = ALU_ADD;
      alu_left     = '0;
      alu_right    = '0;
      ex_rd_addr   = '0;
      ex_reg_write = 1'b0;
      ex_mem_read  = 1'b0;
      ex_mem_write = 1'b0;
      if (v) begin
         alu_control  = q.alu_control;
         alu_left     = q.src_pc ? q.pc : fwd1;
         alu_right    = q.src_imm ? q.imm : fwd2;
         ex_rd_addr   = q.rd_addr;
         ex_reg_write = q.reg_write;
         ex_mem_read  = q.mem_read;
         ex_mem_write = q.mem_write;
      end
   end

   assign ex_valid      = v;
   assign ex_store_data = fwd2;
   assign ex_pc         = q.pc;

`ifdef ID_EX_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_cycles <= '0;
         perf_flush_count  <= '0;
      end else begin
         if (in_valid && !in_ready && perf_stall_cycles != 32'hFFFF_FFFF)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (flush && v && perf_flush_count != 32'hFFFF_FFFF)
            perf_flush_count <= perf_flush_count + 32'd1;
      end
   end
`endif

endmodule
